// File: rtl/credit_rx_fifo.sv
// Credit-based receive FIFO: upstream sends only while it holds a credit, and every
// popped entry hands one credit back through a registered one-cycle pulse.
module credit_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     credit_ret,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW-1:0] PTR_ZERO = PW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    pending_q, pending_d;
  logic             credit_ret_q, credit_ret_d;
  logic             overflow_q, overflow_d;

  logic full_s, push_s, pop_s, drop_s, emit_s;

  assign full_s     = (count_q == CNT_FULL);
  assign out_valid  = (count_q != CNT_ZERO);
  assign out_data   = mem_q[rd_ptr_q];
  assign count      = count_q;
  assign overflow   = overflow_q;
  assign credit_ret = credit_ret_q;

  // A full FIFO still takes a beat when the head leaves on the same edge.
  assign pop_s  = ena & out_valid & out_ready;
  assign push_s = ena & in_valid & (~full_s | pop_s);
  assign drop_s = ena & in_valid & full_s & ~pop_s;
  assign emit_s = (pending_q != CNT_ZERO);

  // Next-state computation for storage, pointers, occupancy and credit bookkeeping.
  always_comb begin
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    pending_d    = pending_q;
    credit_ret_d = 1'b0;
    overflow_d   = overflow_q | drop_s;

    if (push_s) begin
      mem_d[wr_ptr_q] = in_data;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    // Emitting one credit while a pop adds one leaves the owed total unchanged.
    if (ena) begin
      credit_ret_d = emit_s;
      case ({emit_s, pop_s})
        2'b10:   pending_d = pending_q - CNT_ONE;
        2'b01:   pending_d = pending_q + CNT_ONE;
        default: pending_d = pending_q;
      endcase
    end else begin
      credit_ret_d = 1'b0;
      pending_d    = pending_q;
    end
  end

  // Control state; reset restarts the full credit grant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q     <= PTR_ZERO;
      wr_ptr_q     <= PTR_ZERO;
      count_q      <= CNT_ZERO;
      pending_q    <= CNT_FULL;
      credit_ret_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      pending_q    <= pending_d;
      credit_ret_q <= credit_ret_d;
      overflow_q   <= overflow_d;
    end
  end

  // Storage array is not cleared by reset, only protected from writes during it.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      mem_q <= mem_d;
    end
  end

endmodule

// File: tb/tb_credit_rx_fifo.sv
// Directed bench for credit_rx_fifo: expected head values go into a scoreboard queue,
// a negedge monitor checks every accepted pop; credits/flags are checked per cycle.
module tb_credit_rx_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       credit_ret;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic [2:0] count;
  logic       overflow;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];

  credit_rx_fifo #(.DEPTH(4), .WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid), .in_data(in_data),
    .credit_ret(credit_ret), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: an accepted pop must present the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && ena && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected got %0h expected none", out_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (out_data !== e) begin
          errors++;
          $display("FAIL pop_data got %0h expected %0h", out_data, e);
        end
      end
    end
  end

  logic [7:0] fill_a [4] = '{8'h40, 8'h81, 8'hC0, 8'h7F};
  logic [7:0] fill_b [4] = '{8'h55, 8'h66, 8'h77, 8'h88};

  initial begin
    step(); step();
    chk("rst_count", count, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_credit", credit_ret, 0);
    chk("rst_overflow", overflow, 0);

    // Initial credit burst
    rst_n = 1'b1; ena = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("init_burst_credit", credit_ret, (i < 4) ? 1 : 0);
    end
    chk("idle_count", count, 0);
    chk("idle_out_valid", out_valid, 0);

    // Fill with out_ready low
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = fill_a[i]; exp_q.push_back(fill_a[i]);
      step();
      chk("fill_credit", credit_ret, 0);
    end
    in_valid = 1'b0;
    chk("full_count", count, 4);
    chk("full_head", out_data, 8'h40);

    // Drain: each credit follows its pop by one edge
    for (int i = 0; i < 6; i++) begin
      out_ready = (i < 4);
      step();
      chk("drain_credit", credit_ret, (i >= 1 && i <= 4) ? 1 : 0);
    end
    chk("drained_count", count, 0);

    // Overflow then full push+pop
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = fill_b[i]; exp_q.push_back(fill_b[i]);
      step();
    end
    in_data = 8'h11; out_ready = 1'b0;
    step();
    chk("ovf_set", overflow, 1);
    chk("ovf_count", count, 4);
    chk("ovf_head", out_data, 8'h55);
    in_valid = 1'b0;
    step();
    chk("ovf_sticky", overflow, 1);
    in_valid = 1'b1; in_data = 8'h22; out_ready = 1'b1; exp_q.push_back(8'h22);
    step();
    chk("pushpop_count", count, 4);
    chk("pushpop_overflow", overflow, 1);
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    out_ready = 1'b0;
    chk("drain2_count", count, 0);
    chk("drain2_overflow", overflow, 1);
    chk("drain2_scoreboard", exp_q.size(), 0);
    for (int i = 0; i < 3; i++) step();

    // Mid-operation reset with count=3 and overflow set
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 8'(i + 1); exp_q.push_back(8'(i + 1));
      step();
    end
    chk("pre_rst_count", count, 3);
    rst_n = 1'b0; out_ready = 1'b1;
    step();
    exp_q.delete();
    chk("mid_rst_count", count, 0);
    chk("mid_rst_overflow", overflow, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_credit", credit_ret, 0);
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rst_burst_credit", credit_ret, (i < 4) ? 1 : 0);
    end

    // Enable gating with two credits still owed
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step(); chk("gate_pre_credit", credit_ret, 1);
    step(); chk("gate_pre_credit", credit_ret, 1);
    ena = 1'b0; in_valid = 1'b1; in_data = 8'h99; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("gate_credit", credit_ret, 0);
      chk("gate_count", count, 0);
      chk("gate_overflow", overflow, 0);
    end
    ena = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    step(); chk("resume_credit", credit_ret, 1);
    step(); chk("resume_credit", credit_ret, 1);
    step(); chk("resume_credit_end", credit_ret, 0);
    chk("final_scoreboard", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
